// File: rtl/dcache_mem_initiator.sv
// Direct-mapped write-back/write-allocate data cache controller that initiates
// 128-bit block fills and write-backs on memory port 1.
module dcache_mem_initiator #(
  parameter int BLOCKSIZE      = 128,
  parameter int SETS           = 64,
  parameter int BYTE_ADDR_BITS = 4,
  parameter int INDEX_BITS     = 6,
  parameter int TAG_BITS       = 22
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_valid_i,
  input  logic                 cpu_wen_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_wdata_i,
  input  logic [3:0]           cpu_byte_en_i,
  output logic [31:0]          cpu_rdata_o,
  output logic                 cpu_stall_o,
  output logic                 mem_valid_o,
  output logic                 mem_wen_o,
  output logic [31:0]          mem_raddr_o,
  output logic [31:0]          mem_waddr_o,
  output logic [BLOCKSIZE-1:0] mem_wdata_o,
  input  logic                 mem_ready_i,
  input  logic [BLOCKSIZE-1:0] mem_rdata_i
);

  localparam int WORD_BITS = BYTE_ADDR_BITS - 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WB_REQ    = 3'd1,
    WB_WAIT   = 3'd2,
    FILL_REQ  = 3'd3,
    FILL_WAIT = 3'd4
  } state_t;

  state_t state_r, state_s;

  logic [TAG_BITS-1:0]   tag_mem  [SETS];
  logic [BLOCKSIZE-1:0]  data_mem [SETS];
  logic [SETS-1:0]       valid_r;
  logic [SETS-1:0]       dirty_r;

  logic [TAG_BITS-1:0]   tag_s;
  logic [INDEX_BITS-1:0] index_s;
  logic [WORD_BITS-1:0]  word_s;
  logic [BLOCKSIZE-1:0]  line_s;
  logic [BLOCKSIZE-1:0]  merged_s;
  logic                  hit_s;
  logic                  victim_dirty_s;
  logic                  store_hit_s;
  logic                  fill_done_s;
  logic                  stall_s;

  logic                  mem_valid_r;
  logic                  mem_wen_r;
  logic [31:0]           raddr_r;
  logic [31:0]           waddr_r;
  logic [BLOCKSIZE-1:0]  wdata_r;
  logic                  unused_s;

  assign tag_s          = cpu_addr_i[31 -: TAG_BITS];
  assign index_s        = cpu_addr_i[BYTE_ADDR_BITS +: INDEX_BITS];
  assign word_s         = cpu_addr_i[BYTE_ADDR_BITS-1:2];
  assign line_s         = data_mem[index_s];
  assign hit_s          = valid_r[index_s] && (tag_mem[index_s] == tag_s);
  assign victim_dirty_s = valid_r[index_s] && dirty_r[index_s];
  assign store_hit_s    = (state_r == IDLE) && cpu_valid_i && cpu_wen_i && hit_s;
  assign fill_done_s    = (state_r == FILL_WAIT) && mem_ready_i;
  assign unused_s       = ^cpu_addr_i[1:0];

  assign cpu_rdata_o = line_s[32*word_s +: 32];
  assign cpu_stall_o = stall_s;
  assign mem_valid_o = mem_valid_r;
  assign mem_wen_o   = mem_wen_r;
  assign mem_raddr_o = raddr_r;
  assign mem_waddr_o = waddr_r;
  assign mem_wdata_o = wdata_r;

  // Byte-lane merge of store data into the resident line
  always_comb begin
    merged_s = line_s;
    for (int b = 0; b < 4; b++) begin
      merged_s[32*word_s + 8*b +: 8] = cpu_byte_en_i[b] ? cpu_wdata_i[8*b +: 8]
                                                         : line_s[32*word_s + 8*b +: 8];
    end
  end

  // Next-state decode and CPU stall
  always_comb begin
    state_s = state_r;
    stall_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (cpu_valid_i && !hit_s) begin
          stall_s = 1'b1;
          state_s = victim_dirty_s ? WB_REQ : FILL_REQ;
        end else begin
          state_s = IDLE;
        end
      end
      WB_REQ: begin
        stall_s = 1'b1;
        state_s = WB_WAIT;
      end
      WB_WAIT: begin
        stall_s = 1'b1;
        if (mem_ready_i) begin
          state_s = FILL_REQ;
        end else begin
          state_s = WB_WAIT;
        end
      end
      FILL_REQ: begin
        stall_s = 1'b1;
        state_s = FILL_WAIT;
      end
      FILL_WAIT: begin
        stall_s = 1'b1;
        if (mem_ready_i) begin
          state_s = IDLE;
        end else begin
          state_s = FILL_WAIT;
        end
      end
      default: begin
        stall_s = 1'b0;
        state_s = IDLE;
      end
    endcase
    if (rst_i) begin
      stall_s = 1'b0;
    end else begin
      stall_s = stall_s;
    end
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Memory-port request registers; victim is captured once and held through the write-back
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_valid_r <= 1'b0;
      mem_wen_r   <= 1'b0;
      raddr_r     <= 32'h0000_0000;
      waddr_r     <= 32'h0000_0000;
      wdata_r     <= {BLOCKSIZE{1'b0}};
    end else begin
      mem_valid_r <= (state_s == WB_REQ) || (state_s == FILL_REQ);
      mem_wen_r   <= (state_s == WB_REQ);
      if ((state_r == IDLE) && (state_s == WB_REQ)) begin
        waddr_r <= {tag_mem[index_s], index_s, {BYTE_ADDR_BITS{1'b0}}};
        wdata_r <= line_s;
      end
      if (state_s == FILL_REQ) begin
        raddr_r <= {tag_s, index_s, {BYTE_ADDR_BITS{1'b0}}};
      end
    end
  end

  // Valid and dirty bits
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_r <= {SETS{1'b0}};
      dirty_r <= {SETS{1'b0}};
    end else if (fill_done_s) begin
      valid_r[index_s] <= 1'b1;
      dirty_r[index_s] <= 1'b0;
    end else if (store_hit_s) begin
      dirty_r[index_s] <= 1'b1;
    end
  end

  // Tag and data arrays (not reset)
  always_ff @(posedge clk_i) begin
    if (fill_done_s) begin
      tag_mem[index_s]  <= tag_s;
      data_mem[index_s] <= mem_rdata_i;
    end else if (store_hit_s) begin
      data_mem[index_s] <= merged_s;
    end
  end

endmodule

// File: tb/tb_dcache_mem_initiator.sv
// Table-driven bench for dcache_mem_initiator with a behavioural block memory
// that answers each request after a programmable delay.
module tb_dcache_mem_initiator;

  logic         clk;
  logic         rst_i;
  logic         cpu_valid_i;
  logic         cpu_wen_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_wdata_i;
  logic [3:0]   cpu_byte_en_i;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_stall_o;
  logic         mem_valid_o;
  logic         mem_wen_o;
  logic [31:0]  mem_raddr_o;
  logic [31:0]  mem_waddr_o;
  logic [127:0] mem_wdata_o;
  logic         mem_ready_i;
  logic [127:0] mem_rdata_i;

  logic         resp_ready;
  logic         spur_ready;
  int           n_chk;
  int           n_fail;
  int           reads;
  int           writes;
  int           viol;
  int           cnt;
  int           extra;
  logic         pend_rd;
  logic         prev_valid;
  logic [31:0]  last_raddr;
  logic [31:0]  last_waddr;
  logic [127:0] last_wdata;
  logic [127:0] mem_model [logic [31:0]];

  assign mem_ready_i = resp_ready | spur_ready;

  dcache_mem_initiator dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .cpu_valid_i   (cpu_valid_i),
    .cpu_wen_i     (cpu_wen_i),
    .cpu_addr_i    (cpu_addr_i),
    .cpu_wdata_i   (cpu_wdata_i),
    .cpu_byte_en_i (cpu_byte_en_i),
    .cpu_rdata_o   (cpu_rdata_o),
    .cpu_stall_o   (cpu_stall_o),
    .mem_valid_o   (mem_valid_o),
    .mem_wen_o     (mem_wen_o),
    .mem_raddr_o   (mem_raddr_o),
    .mem_waddr_o   (mem_waddr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_ready_i   (mem_ready_i),
    .mem_rdata_i   (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] blk(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {4{a}};
  endfunction

  // Memory responder: Ready comes 1+extra cycles after the Valid pulse
  always @(negedge clk) begin
    resp_ready = 1'b0;
    if (rst_i) begin
      cnt = 0;
    end else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          resp_ready  = 1'b1;
          mem_rdata_i = pend_rd ? blk(last_raddr) : 128'h0;
        end
      end
      if (mem_valid_o) begin
        if (prev_valid) viol++;
        if (mem_wen_o) begin
          writes++;
          last_waddr = mem_waddr_o;
          last_wdata = mem_wdata_o;
          mem_model[mem_waddr_o] = mem_wdata_o;
          pend_rd = 1'b0;
        end else begin
          reads++;
          last_raddr = mem_raddr_o;
          pend_rd = 1'b1;
        end
        cnt = 1 + extra;
      end
    end
    prev_valid = mem_valid_o;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a falling edge; returns stall cycles seen and the data at completion
  task automatic access(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output int stalls, output logic [31:0] rdata);
    cpu_valid_i   = 1'b1;
    cpu_wen_i     = wen;
    cpu_addr_i    = addr;
    cpu_wdata_i   = wdata;
    cpu_byte_en_i = be;
    stalls = 0;
    #1;
    while (cpu_stall_o && stalls < 100) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    rdata = cpu_rdata_o;
    @(posedge clk);
    @(negedge clk);
    cpu_valid_i = 1'b0;
    cpu_wen_i   = 1'b0;
  endtask

  typedef struct {
    logic         wen;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [3:0]   be;
    int           stalls;
    logic         chk_rd;
    logic [31:0]  rdata;
    int           reads;
    int           writes;
    logic [31:0]  waddr;
    logic [127:0] wblk;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  initial begin
    int          st;
    int          r0;
    int          w0;
    logic [31:0] rd;

    n_chk = 0; n_fail = 0; reads = 0; writes = 0; viol = 0; cnt = 0; extra = 0;
    pend_rd = 1'b0; prev_valid = 1'b0; resp_ready = 1'b0; spur_ready = 1'b0;
    last_raddr = 32'h0; last_waddr = 32'h0; last_wdata = 128'h0; mem_rdata_i = 128'h0;
    rst_i = 1'b1; cpu_valid_i = 1'b0; cpu_wen_i = 1'b0; cpu_addr_i = 32'h0;
    cpu_wdata_i = 32'h0; cpu_byte_en_i = 4'h0;

    mem_model[32'h0001_0000] = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    mem_model[32'h0001_0400] = 128'h44444444_33333333_22222222_11111111;

    vecs[0]  = '{1'b0, 32'h00010000, 32'h0, 4'h0, 3, 1'b1, 32'hAAAAAAAA, 1, 0, 32'h0, 128'h0};
    vecs[1]  = '{1'b0, 32'h00010004, 32'h0, 4'h0, 0, 1'b1, 32'hBBBBBBBB, 0, 0, 32'h0, 128'h0};
    vecs[2]  = '{1'b1, 32'h00010000, 32'h12345678, 4'b0011, 0, 1'b0, 32'h0, 0, 0, 32'h0, 128'h0};
    vecs[3]  = '{1'b0, 32'h00010000, 32'h0, 4'h0, 0, 1'b1, 32'hAAAA5678, 0, 0, 32'h0, 128'h0};
    vecs[4]  = '{1'b0, 32'h00010400, 32'h0, 4'h0, 5, 1'b1, 32'h11111111, 1, 1, 32'h00010000,
                 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAA5678};
    vecs[5]  = '{1'b0, 32'h00010000, 32'h0, 4'h0, 3, 1'b1, 32'hAAAA5678, 1, 0, 32'h0, 128'h0};
    vecs[6]  = '{1'b0, 32'h0001000C, 32'h0, 4'h0, 0, 1'b1, 32'hDDDDDDDD, 0, 0, 32'h0, 128'h0};
    vecs[7]  = '{1'b1, 32'h00020018, 32'hCAFEF00D, 4'b1111, 3, 1'b0, 32'h0, 1, 0, 32'h0, 128'h0};
    vecs[8]  = '{1'b0, 32'h00020018, 32'h0, 4'h0, 0, 1'b1, 32'hCAFEF00D, 0, 0, 32'h0, 128'h0};
    vecs[9]  = '{1'b0, 32'h00020014, 32'h0, 4'h0, 0, 1'b1, 32'h00020010, 0, 0, 32'h0, 128'h0};
    vecs[10] = '{1'b1, 32'h00020014, 32'hA1B2C3D4, 4'b1010, 0, 1'b0, 32'h0, 0, 0, 32'h0, 128'h0};
    vecs[11] = '{1'b0, 32'h00020014, 32'h0, 4'h0, 0, 1'b1, 32'hA102C310, 0, 0, 32'h0, 128'h0};
    vecs[12] = '{1'b0, 32'h00020418, 32'h0, 4'h0, 5, 1'b1, 32'h00020410, 1, 1, 32'h00020010,
                 128'h00020010_CAFEF00D_A102C310_00020010};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", cpu_stall_o, 1'b0);
    chk("rst_mvalid", mem_valid_o, 1'b0);
    chk("rst_mwen", mem_wen_o, 1'b0);
    chk("rst_raddr", mem_raddr_o, 32'h0);
    chk("rst_waddr", mem_waddr_o, 32'h0);
    chk("rst_wdata", mem_wdata_o, 128'h0);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      r0 = reads;
      w0 = writes;
      access(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].be, st, rd);
      chk($sformatf("v%0d_stalls", i), st, vecs[i].stalls);
      if (vecs[i].chk_rd) chk($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
      chk($sformatf("v%0d_reads", i), reads - r0, vecs[i].reads);
      chk($sformatf("v%0d_writes", i), writes - w0, vecs[i].writes);
      if (vecs[i].reads > 0) chk($sformatf("v%0d_raddr", i), last_raddr, vecs[i].addr & 32'hFFFF_FFF0);
      if (vecs[i].writes > 0) begin
        chk($sformatf("v%0d_waddr", i), last_waddr, vecs[i].waddr);
        chk($sformatf("v%0d_wdata", i), last_wdata, vecs[i].wblk);
      end
    end

    // Slow memory: Ready withheld for 7 cycles in FILL_WAIT
    extra = 7;
    r0 = reads;
    access(1'b0, 32'h00030000, 32'h0, 4'h0, st, rd);
    chk("slow_stalls", st, 10);
    chk("slow_rdata", rd, 32'h00030000);
    chk("slow_reads", reads - r0, 1);
    extra = 0;

    // Reset in FILL_WAIT, then a stray Ready
    extra = 20;
    cpu_valid_i = 1'b1; cpu_wen_i = 1'b0; cpu_addr_i = 32'h00040000; cpu_byte_en_i = 4'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("fw_stall", cpu_stall_o, 1'b1);
    rst_i = 1'b1;
    #1;
    chk("fw_rst_stall", cpu_stall_o, 1'b0);
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    cpu_valid_i = 1'b0;
    extra = 0;
    #1;
    chk("post_rst_raddr", mem_raddr_o, 32'h0);
    @(negedge clk);
    spur_ready = 1'b1;
    @(negedge clk);
    spur_ready = 1'b0;
    #1;
    chk("post_rst_stall", cpu_stall_o, 1'b0);
    chk("post_rst_mvalid", mem_valid_o, 1'b0);
    @(negedge clk);
    r0 = reads;
    access(1'b0, 32'h00040000, 32'h0, 4'h0, st, rd);
    chk("rearm_stalls", st, 3);
    chk("rearm_reads", reads - r0, 1);
    chk("rearm_rdata", rd, 32'h00040000);

    // Spurious Ready while idle
    r0 = reads;
    w0 = writes;
    spur_ready = 1'b1;
    @(negedge clk);
    spur_ready = 1'b0;
    #1;
    chk("spur_stall", cpu_stall_o, 1'b0);
    chk("spur_mvalid", mem_valid_o, 1'b0);
    @(negedge clk);
    access(1'b0, 32'h00040004, 32'h0, 4'h0, st, rd);
    chk("spur_hit_stalls", st, 0);
    chk("spur_hit_rdata", rd, 32'h00040000);
    chk("spur_traffic", (reads - r0) + (writes - w0), 0);

    chk("no_back_to_back_valid", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_mem_initiator.md
Name: dcache_mem_initiator

Overview:
- Direct-mapped, write-back, write-allocate data cache controller between the CPU load/store stage and main-memory port 1.
- It is the initiator side of the block-transfer protocol: it issues 128-bit block reads (fills) and block writes (write-backs), then waits for the memory's Ready pulse.
- Hits complete in the request cycle. Misses stall the CPU until the line is resident.

Parameters:
- BLOCKSIZE, 128, line width in bits; must equal the memory block width.
- SETS, 64, number of lines; power of two.
- BYTE_ADDR_BITS, 4, log2(BLOCKSIZE/8); block-offset bits.
- INDEX_BITS, 6, log2(SETS).
- TAG_BITS, 22, 32-INDEX_BITS-BYTE_ADDR_BITS.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- cpu_valid_i  in  1  CPU access request.
- cpu_wen_i  in  1  1 = store, 0 = load.
- cpu_addr_i  in  32  byte address; bits [1:0] ignored (word access).
- cpu_wdata_i  in  32  store data.
- cpu_byte_en_i  in  4  store byte enables; bit n enables byte lane n.
- cpu_rdata_o  out  32  load data; valid when cpu_valid_i=1 and cpu_stall_o=0.
- cpu_stall_o  out  1  1 = request not complete, CPU must hold all inputs stable.
- mem_valid_o  out  1  memory request, one-cycle pulse.
- mem_wen_o  out  1  1 = block write (write-back), 0 = block read (fill).
- mem_raddr_o  out  32  fill address, low BYTE_ADDR_BITS forced to 0.
- mem_waddr_o  out  32  write-back address, low BYTE_ADDR_BITS forced to 0.
- mem_wdata_o  out  BLOCKSIZE  victim line data.
- mem_ready_i  in  1  memory response strobe.
- mem_rdata_i  in  BLOCKSIZE  fill data, valid when mem_ready_i=1 for a read.

Behaviour:
Reset
- rst_i asynchronously clears all valid and dirty bits, sets the FSM to IDLE, and drives mem_valid_o=0, mem_wen_o=0, cpu_stall_o=0 and all address/data outputs to 0.
- Tag and data arrays are not reset.
- Reset mid-transfer abandons the transfer. Any mem_ready_i arriving afterwards is ignored in IDLE.

Address split
- tag = addr[31:10], index = addr[9:4], word = addr[3:2] (defaults).

Hit (IDLE, cpu_valid_i=1, line valid and tag match)
- cpu_stall_o=0 in the same cycle.
- Load: cpu_rdata_o = selected 32-bit word, combinational.
- Store: the enabled bytes are written at the next rising edge and the dirty bit is set.

Miss
- cpu_stall_o rises combinationally in the request cycle and stays high until the hit cycle after the fill.

FSM states and transitions
- IDLE
  - Miss with victim valid and dirty -> WB_REQ.
  - Miss otherwise -> FILL_REQ.
  - cpu_valid_i=0: stay in IDLE, no stall.
- WB_REQ
  - One cycle: mem_valid_o=1, mem_wen_o=1, mem_waddr_o={victim tag, index, 4'b0}, mem_wdata_o=victim line.
  - -> WB_WAIT.
- WB_WAIT
  - mem_valid_o=0. Wait any number of cycles for mem_ready_i=1, then -> FILL_REQ.
- FILL_REQ
  - One cycle: mem_valid_o=1, mem_wen_o=0, mem_raddr_o={cpu tag, index, 4'b0}.
  - -> FILL_WAIT.
- FILL_WAIT
  - On mem_ready_i=1: write mem_rdata_i into the line, set tag, valid=1, dirty=0, then -> IDLE.
  - The retried access then hits: a store merges and sets dirty in that cycle.

Handshake rules
- mem_valid_o is never high for two consecutive cycles.
- At most one outstanding request.
- mem_ready_i is ignored in every state except WB_WAIT and FILL_WAIT.
- With the current memory, Ready arrives one cycle after Valid, so a clean miss costs 3 stall cycles and a dirty miss costs 5.

Write-back data
- The victim line and tag are latched at IDLE->WB_REQ and held until the WB_WAIT exit. mem_wdata_o must not depend on arrays being refilled.

CPU changes during stall
- Not permitted; behaviour is undefined.

Test Plan:
- Reset, then load 0x00010000 (memory block = 0x...DDDDCCCCBBBBAAAA) -> stall for 3 cycles; one read pulse with raddr 0x00010000; cpu_rdata_o=0xAAAAAAAA; re-load 0x00010004 -> no stall, 0xBBBBBBBB.
- Store 0x12345678, byte_en 4'b0011, to resident word 0x00010000 -> no stall; next load returns 0xAAAA5678; no memory traffic.
- Dirty conflict: after the previous test, load 0x00010400 (same index 0) -> write pulse with waddr 0x00010000 and wdata word0=0xAAAA5678, then read pulse raddr 0x00010400; 5 stall cycles; reloading 0x00010000 then returns 0xAAAA5678.
- Slow memory: hold mem_ready_i low for 7 cycles in FILL_WAIT -> mem_valid_o single-cycle pulse, stall held throughout, fill completes on Ready.
- Assert rst_i during FILL_WAIT, then pulse mem_ready_i -> FSM in IDLE, line not valid, next access to the same address misses again.
- cpu_valid_i=0 with a spurious mem_ready_i=1 -> no state change, stall 0, mem_valid_o 0.
